// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and hands one- or two-word instructions to decode.
// Two-word (LDS/STS/JMP/CALL) assembly is enabled by defining IFETCH_TWO_WORD_EN.
module instr_fetch #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_ext,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_two,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

`ifdef IFETCH_TWO_WORD_EN
    localparam bit TWO_WORD_EN = 1'b1;
`else
    localparam bit TWO_WORD_EN = 1'b0;
`endif

    typedef enum logic {S_WORD1, S_WORD2} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] word1_pc;
    logic [DATA_WIDTH-1:0] word1;
    logic                  slot_free;
    logic                  advance;
    logic                  two_word;

    assign rom_addr  = pc;
    assign slot_free = !instr_valid || instr_ready;
    assign advance   = slot_free && !stall && !branch_valid;

    // LDS/STS or JMP/CALL opcode; folds to 0 when the feature is disabled, removing S_WORD2.
    assign two_word = TWO_WORD_EN &&
        (((rom_data & DATA_WIDTH'(16'hFC0F)) == DATA_WIDTH'(16'h9000)) ||
         ((rom_data & DATA_WIDTH'(16'hFE0C)) == DATA_WIDTH'(16'h940C)));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= ADDR_WIDTH'(RESET_PC);
            state       <= S_WORD1;
            instr       <= '0;
            instr_ext   <= '0;
            instr_pc    <= '0;
            instr_two   <= 1'b0;
            instr_valid <= 1'b0;
            word1       <= '0;
            word1_pc    <= '0;
        end else if (branch_valid) begin
            // Redirect drops both the offered instruction and any half-assembled one.
            pc          <= branch_target;
            state       <= S_WORD1;
            instr_valid <= 1'b0;
        end else if (advance) begin
            pc <= pc + ADDR_WIDTH'(1);
            case (state)
                S_WORD1: begin
                    if (two_word) begin
                        // Slot is free here, so any offered instruction was just consumed.
                        word1       <= rom_data;
                        word1_pc    <= pc;
                        state       <= S_WORD2;
                        instr_valid <= 1'b0;
                    end else begin
                        instr       <= rom_data;
                        instr_ext   <= '0;
                        instr_two   <= 1'b0;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                    end
                end
                S_WORD2: begin
                    instr       <= word1;
                    instr_ext   <= rom_data;
                    instr_two   <= 1'b1;
                    instr_pc    <= word1_pc;
                    instr_valid <= 1'b1;
                    state       <= S_WORD1;
                end
            endcase
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus randomized traffic
// checked against a program-walk model of the instruction stream.
module tb_instr_fetch;

`ifdef IFETCH_TWO_WORD_EN
    localparam bit TWO_EN = 1'b1;
`else
    localparam bit TWO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        stall;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic [15:0] instr;
    logic [15:0] instr_ext;
    logic [7:0]  instr_pc;
    logic        instr_two;
    logic        instr_valid;
    logic        instr_ready;

    logic [15:0] rom [256];
    int          checks   = 0;
    int          failures = 0;

    instr_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RESET_PC(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_ext     (instr_ext),
        .instr_pc      (instr_pc),
        .instr_two     (instr_two),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    // ROM registered on the falling edge
    always @(negedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_two(input logic [15:0] w);
        return TWO_EN && (((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stream model: wpc is the address of the next instruction decode should see.
    initial begin
        logic [7:0]  wpc;
        logic [7:0]  nxt;
        logic [7:0]  tgt;
        logic [15:0] w;
        bit          two;
        bit          pend_reset;
        bit          pend_branch;
        wpc         = 8'd0;
        tgt         = 8'd0;
        pend_reset  = 1'b0;
        pend_branch = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_reset) begin
                chk("sb_reset_valid", 32'(instr_valid), 32'd0);
                chk("sb_reset_outs", {instr, instr_ext}, 32'd0);
                chk("sb_reset_pc", {22'd0, instr_two, instr_pc, rom_addr}, 32'd0);
            end
            if (pend_branch) begin
                chk("sb_branch_addr", 32'(rom_addr), 32'(tgt));
                chk("sb_branch_valid", 32'(instr_valid), 32'd0);
            end
            pend_reset  = 1'b0;
            pend_branch = 1'b0;
            w   = rom[wpc];
            two = is_two(w);
            nxt = wpc + 8'd1;
            if (instr_valid === 1'b1) begin
                chk("sb_instr", 32'(instr), 32'(w));
                chk("sb_pc", 32'(instr_pc), 32'(wpc));
                chk("sb_two", 32'(instr_two), 32'(two));
                chk("sb_ext", 32'(instr_ext), two ? 32'(rom[nxt]) : 32'd0);
            end
            if (reset === 1'b1) begin
                wpc        = 8'd0;
                pend_reset = 1'b1;
            end else if (branch_valid === 1'b1) begin
                wpc         = branch_target;
                tgt         = branch_target;
                pend_branch = 1'b1;
            end else if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                wpc = wpc + (two ? 8'd2 : 8'd1);
            end
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       rom[i] = 16'h9000 | 16'($urandom & 32'h03F0);
                1:       rom[i] = 16'h940C | 16'($urandom & 32'h01F3);
                default: rom[i] = 16'($urandom);
            endcase
        end
        rom[0]  = 16'h0000; rom[1] = 16'h2411; rom[2] = 16'hE0A5; rom[3] = 16'h0001;
        rom[4]  = 16'h940C; rom[5] = 16'h0010; rom[6] = 16'h1111; rom[7] = 16'h2222;
        rom[8]  = 16'h3333; rom[9] = 16'h9000; rom[10] = 16'h0100;
        rom[32] = 16'h4444; rom[255] = 16'h0000;

        reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 8'd0; instr_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", {instr, instr_ext}, 32'd0);
        chk("rst_pc", {22'd0, instr_two, instr_pc, rom_addr}, 32'd0);
        reset = 1'b0;

        // straight-line single-word stream
        cyc(); chk("s1_valid", 32'(instr_valid), 32'd1); chk("s1_i", {instr, 8'd0, instr_pc}, 32'h0000_0000);
        cyc(); chk("s2_i", {instr, 8'd0, instr_pc}, 32'h2411_0001);
        cyc(); chk("s3_i", {instr, 8'd0, instr_pc}, 32'hE0A5_0002);
        cyc(); chk("s4_i", {instr, 8'd0, instr_pc}, 32'h0001_0003);
        // JMP at 4
        cyc();
        chk("jmp_bubble_valid", 32'(instr_valid), TWO_EN ? 32'd0 : 32'd1);
        chk("jmp_k5", {instr, 8'd0, instr_pc}, TWO_EN ? 32'h0001_0003 : 32'h940C_0004);
        cyc();
        chk("jmp_valid", 32'(instr_valid), 32'd1);
        chk("jmp_i", {instr, 8'd0, instr_pc}, TWO_EN ? 32'h940C_0004 : 32'h0010_0005);
        chk("jmp_ext", {instr_ext, 15'd0, instr_two}, TWO_EN ? 32'h0010_0001 : 32'h0000_0000);
        cyc(); chk("after_jmp", {instr, 8'd0, instr_pc}, 32'h1111_0006);
        cyc(); chk("pc7", {instr, 8'd0, instr_pc}, 32'h2222_0007);
        // backpressure
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_i", {instr, instr_pc, rom_addr}, 32'h2222_0708);
        end
        instr_ready = 1'b1;
        cyc(); chk("release_i", {instr, 7'd0, instr_valid, instr_pc}, 32'h3333_0108);
        cyc();
        chk("lds_valid", 32'(instr_valid), TWO_EN ? 32'd0 : 32'd1);
        chk("lds_i", {instr, 8'd0, instr_pc}, TWO_EN ? 32'h3333_0008 : 32'h9000_0009);
        // redirect while half-assembled
        branch_valid = 1'b1; branch_target = 8'h20;
        cyc();
        chk("br_valid", 32'(instr_valid), 32'd0);
        chk("br_addr", 32'(rom_addr), 32'h20);
        branch_valid = 1'b0;
        cyc(); chk("br_tgt", {instr, 7'd0, instr_valid, instr_pc}, 32'h4444_0120);
        // pc wrap
        branch_valid = 1'b1; branch_target = 8'hFF;
        cyc(); chk("wrap_br", {instr_valid, rom_addr}, 32'h0FF);
        branch_valid = 1'b0;
        cyc(); chk("wrap_ff", {instr, 7'd0, instr_valid, instr_pc}, 32'h0000_01FF);
        cyc(); chk("wrap_00", {instr, 7'd0, instr_valid, instr_pc}, 32'h0000_0100);
        // stall consumes the offered instruction but captures nothing
        stall = 1'b1;
        cyc(); chk("stall1", {instr_valid, rom_addr}, 32'h001);
        cyc(); chk("stall2", {instr_valid, rom_addr}, 32'h001);
        stall = 1'b0;
        cyc(); chk("unstall", {instr, 7'd0, instr_valid, instr_pc}, 32'h2411_0101);
        // branch beats stall
        stall = 1'b1; branch_valid = 1'b1; branch_target = 8'h20;
        cyc(); chk("stall_br", {instr_valid, rom_addr}, 32'h020);
        stall = 1'b0; branch_valid = 1'b0;
        cyc(); chk("stall_br_tgt", {instr, 7'd0, instr_valid, instr_pc}, 32'h4444_0120);
        // reset mid-stream
        reset = 1'b1;
        cyc();
        chk("mid_rst", {instr, instr_ext}, 32'd0);
        chk("mid_rst_pc", {21'd0, instr_valid, instr_two, instr_pc, rom_addr}, 32'd0);
        rom[255] = 16'h940C;
        cyc();
        // two-word instruction at the last address
        reset = 1'b0; branch_valid = 1'b1; branch_target = 8'hFF;
        cyc(); chk("last_br", {instr_valid, rom_addr}, 32'h0FF);
        branch_valid = 1'b0;
        cyc(); chk("last_b1", {instr_valid, rom_addr}, TWO_EN ? 32'h000 : 32'h100);
        cyc();
        chk("last_b2", {instr, 7'd0, instr_valid, instr_pc}, TWO_EN ? 32'h940C_01FF : 32'h0000_0100);
        chk("last_b2_two", {instr_ext, 15'd0, instr_two}, TWO_EN ? 32'h0000_0001 : 32'h0000_0000);
        cyc(); chk("last_b3", {instr, instr_pc, rom_addr}, 32'h2411_0102);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset         = ($urandom_range(0, 199) == 0);
            branch_valid  = ($urandom_range(0, 19) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
            stall         = ($urandom_range(0, 4) == 0);
            instr_ready   = ($urandom_range(0, 9) < 7);
        end
        reset = 1'b0; branch_valid = 1'b0; stall = 1'b0; instr_ready = 1'b1;

        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            cyc();
            seen = (instr_valid === 1'b1);
        end
        chk("liveness", 32'(seen), 32'd1);
        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
